// File: rtl/float_dec_formatter.sv
// float_dec_formatter
//   Turns the integer part, binary fraction and sign produced by the
//   IEEE-754 binary-to-decimal converter into packed BCD digits for the
//   display/UART stages.
//   The integer part is converted by double-dabble (shift-add-3), one bit
//   per cycle. The fraction is converted by repeated multiply-by-10, one
//   digit per cycle. Fraction digits are truncated, not rounded.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        request a conversion; only looked at while idle
//   in_floor     unsigned integer magnitude (INT_W bits)
//   in_frac      unsigned binary fraction, MSB weight 2^-1 (FRAC_W bits)
//   in_sign      sign, 1 = negative
//   busy         high from the cycle after acceptance until done rises
//   done         one-cycle pulse when int_bcd/frac_bcd/sign_out are new
//   int_bcd      integer BCD, units digit in bits [3:0]
//   frac_bcd     fraction BCD, 10^-1 digit in the MSB nibble
//   sign_out     registered copy of the accepted in_sign
module float_dec_formatter #(
  parameter int INT_W       = 128,
  parameter int INT_DIGITS  = 39,  // must cover 2^INT_W-1 in decimal
  parameter int FRAC_W      = 128,
  parameter int FRAC_DIGITS = 8    // must not exceed INT_W (shared counter)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [INT_W-1:0]           in_floor,
  input  logic [FRAC_W-1:0]          in_frac,
  input  logic                       in_sign,
  output logic                       busy,
  output logic                       done,
  output logic [4*INT_DIGITS-1:0]    int_bcd,
  output logic [4*FRAC_DIGITS-1:0]   frac_bcd,
  output logic                       sign_out
);

  localparam int CNT_W = $clog2(INT_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INT,
    S_FRAC,
    S_FIN
  } state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [INT_W-1:0]           shift_q, shift_d;
  logic [4*INT_DIGITS-1:0]    bcd_q, bcd_d;
  logic [FRAC_W-1:0]          frac_q, frac_d;
  logic [4*FRAC_DIGITS-1:0]   fbcd_q, fbcd_d;
  logic                       sign_q, sign_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [4*INT_DIGITS-1:0]    int_bcd_q, int_bcd_d;
  logic [4*FRAC_DIGITS-1:0]   frac_bcd_q, frac_bcd_d;
  logic                       sign_out_q, sign_out_d;

  // Datapath helpers, evaluated every cycle and used only in their state.
  logic [4*INT_DIGITS-1:0]    bcd_adj;
  logic [FRAC_W+3:0]          prod10;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < INT_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    // frac*10 without a multiplier; the top nibble is the next decimal digit.
    prod10 = ({4'b0000, frac_q} << 3) + ({4'b0000, frac_q} << 1);
  end

  always_comb begin
    // NOTE: every _d starts from its _q (hold) so no path leaves a
    // variable unassigned; otherwise the tool would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    frac_d     = frac_q;
    fbcd_d     = fbcd_q;
    sign_d     = sign_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    int_bcd_d  = int_bcd_q;
    frac_bcd_d = frac_bcd_q;
    sign_out_d = sign_out_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d = in_floor;
          frac_d  = in_frac;
          sign_d  = in_sign;
          bcd_d   = '0;
          fbcd_d  = '0;
          cnt_d   = CNT_W'(INT_W);
          busy_d  = 1'b1;
          state_d = S_INT;
        end
      end

      S_INT: begin
        {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
        cnt_d            = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = CNT_W'(FRAC_DIGITS);
          state_d = S_FRAC;
        end
      end

      S_FRAC: begin
        frac_d = prod10[FRAC_W-1:0];
        // New digit enters at the LSB so the first one ends up on top.
        fbcd_d = (fbcd_q << 4) | {{(4*FRAC_DIGITS-4){1'b0}}, prod10[FRAC_W+3:FRAC_W]};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        int_bcd_d  = bcd_q;
        frac_bcd_d = fbcd_q;
        sign_out_d = sign_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the wide shift/BCD/fraction registers are reset along with the
  // control state, so an aborted conversion never leaves stale digits behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      bcd_q      <= '0;
      frac_q     <= '0;
      fbcd_q     <= '0;
      sign_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      int_bcd_q  <= '0;
      frac_bcd_q <= '0;
      sign_out_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop sees the pre-edge
      // values of the others, independent of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      frac_q     <= frac_d;
      fbcd_q     <= fbcd_d;
      sign_q     <= sign_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      int_bcd_q  <= int_bcd_d;
      frac_bcd_q <= frac_bcd_d;
      sign_out_q <= sign_out_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign int_bcd  = int_bcd_q;
  assign frac_bcd = frac_bcd_q;
  assign sign_out = sign_out_q;

endmodule
